pref_issue_queue: RTL and testbench
===================================

// Module: pref_issue_queue
// PURPOSE
//  Buffers up to 3 prefetch candidates per cycle from the IP-stride prefetcher.
//  Issues them one per cycle, oldest first, to the L2 request port over a valid/ready handshake.
//  Sits between the prefetcher outputs and the cache miss/request arbiter.
//  Drops candidates on overflow and counts the drops.
// PARAMETERS
//  DEPTH        8    FIFO entries, power of 2, >=4
//  FILTER_SIZE  4    recently-issued block addresses kept for dedup (PREF_DEDUP_EN only)
//  CNT_W        16   width of the saturating statistics counters
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  en_i         in   1      1 = accept new candidates; queue drains regardless
//  flush_i      in   1      discard all queued (and filter) entries
//  cand_addr1_i in   64     candidate 1 byte address (prefetch degree 3, nearest first)
//  cand_vld1_i  in   1      candidate 1 valid
//  cand_addr2_i in   64     candidate 2 byte address
//  cand_vld2_i  in   1      candidate 2 valid
//  cand_addr3_i in   64     candidate 3 byte address
//  cand_vld3_i  in   1      candidate 3 valid
//  req_valid_o  out  1      request valid, = FIFO non-empty
//  req_addr_o   out  64     block-aligned address at FIFO head
//  req_ready_i  in   1      downstream accepts when req_valid_o & req_ready_i
//  occupancy_o  out  $clog2(DEPTH+1)  current entry count
//  drop_cnt_o   out  CNT_W  saturating count of candidates dropped for lack of space
// BEHAVIOUR
//  - Reset (async on rst_n low; released synchronously by the reset tree):
//    FIFO empty; req_valid_o=0, req_addr_o=0, occupancy_o=0, drop_cnt_o=0; filter invalid.
//  - Alignment: stored address = cand_addr & ~64'h3F (block size 64 B).
//  - Enqueue, cycle N, only if en_i & !flush_i:
//    - Valid candidates are taken in order 1, 2, 3.
//    - free = DEPTH - occupancy at start of cycle N. A pop in cycle N does not add space in cycle N.
//    - The first min(n_valid, free) valid candidates are written.
//    - The rest are dropped; drop_cnt_o += dropped, saturating at all-ones.
//    - If en_i=0, candidates are ignored and not counted.
//  - Latency: a candidate enqueued in cycle N is visible at req_* in cycle N+1 at the earliest.
//  - Dequeue: on req_valid_o & req_ready_i the head pops at the next edge.
//    - req_addr_o holds stable while req_valid_o & !req_ready_i.
//    - Simultaneous enqueue and pop: occupancy = old + written - 1.
//  - Pointers: rd/wr are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty come from the
//    occupancy counter, never from pointer equality.
//  - flush_i, cycle N:
//    - A handshake completing in cycle N is honoured (the request counts as sent).
//    - All entries are then discarded; occupancy=0 and req_valid_o=0 in cycle N+1.
//    - Candidates presented in cycle N are discarded and not counted as drops.
//  - Full queue + 3 valid candidates + ready=1 -> all 3 dropped (free=0), head pops.
//  - rst_n asserted mid-handshake -> request abandoned, outputs to reset values immediately.
// CONFIGURATION
//  - Macro PREF_DEDUP_EN defined:
//    - A candidate is suppressed if its aligned address equals:
//      - any valid FIFO entry,
//      - any valid filter entry, or
//      - an earlier candidate written in the same cycle.
//    - The filter records each issued address on handshake, with round-robin replacement.
//    - Suppressed candidates do not consume space and are not drops.
//    - Extra output dup_cnt_o [CNT_W] counts suppressions, saturating.
//    - flush_i also invalidates the filter.
//  - Macro undefined:
//    - No filter, no dup_cnt_o port.
//    - Duplicates are queued and issued normally.
// STRUCTURE
//  - Package pref_pkg: ADDR_SIZE=64, LOG2_BLOCK_SIZE=6, LOG2_PAGE_SIZE=12;
//    typedefs addr_t, cla_t; function blk_align(addr_t).
//  - Sub-module pref_dedup_filter: FILTER_SIZE-entry CAM with 3 lookup ports, 1 insert port,
//    clear. Instantiated only under PREF_DEDUP_EN.
//  - Top level: multi-write FIFO (up to 3 writes, 1 read per cycle), occupancy and drop counters.
// TESTING
//  1. Reset, 3 valid cands 0x1000/0x1040/0x1080, ready=1 -> issued 0x1000,0x1040,0x1080
//     on consecutive cycles starting N+1; occupancy 0 afterwards.
//  2. DEPTH=8, ready=0, 3 cands per cycle for 3 cycles -> occupancy 8, drop_cnt_o=1;
//     4th cycle of 3 cands -> drop_cnt_o=4.
//  3. Backpressure: ready low 5 cycles with head 0x2000 -> req_addr_o holds 0x2000, valid held;
//     ready high -> pop next edge.
//  4. Cand 0x30FF -> req_addr_o=0x30C0 (alignment); en_i=0 with valid cands -> no enqueue,
//     drop_cnt_o unchanged.
//  5. Occupancy 5, flush_i with handshake and 3 new cands -> one request sent, then
//     occupancy 0, req_valid_o=0, drop_cnt_o unchanged.
//  6. PREF_DEDUP_EN: issue 0x4000, then cands 0x4000/0x4040/0x4040 -> only 0x4040 enqueued,
//     dup_cnt_o=2; rst_n low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/pref_pkg.sv
// Shared types and helpers for the prefetch issue path.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package pref_pkg;

    localparam int ADDR_SIZE       = 64;
    localparam int LOG2_BLOCK_SIZE = 6;
    localparam int LOG2_PAGE_SIZE  = 12;

    typedef logic [ADDR_SIZE-1:0]                 addr_t;
    // Cache-line address: byte address with the block offset removed.
    typedef logic [ADDR_SIZE-LOG2_BLOCK_SIZE-1:0] cla_t;

    // Clears the block-offset bits so every queued request names a whole line.
    function automatic addr_t blk_align(addr_t a);
        return a & ~addr_t'((64'd1 << LOG2_BLOCK_SIZE) - 64'd1);
    endfunction

endpackage

// File: rtl/pref_issue_queue_if.sv
// Candidate bus from the prefetcher plus the L2 request valid/ready handshake.
// Latency: none (wires only).
// Backpressure: req_ready_i stalls the head; candidates have no ready and are dropped instead.
// Modports: master = prefetcher/arbiter side, slave = issue queue.
interface pref_issue_queue_if;
    import pref_pkg::*;

    addr_t cand_addr1_i;
    logic  cand_vld1_i;
    addr_t cand_addr2_i;
    logic  cand_vld2_i;
    addr_t cand_addr3_i;
    logic  cand_vld3_i;
    logic  req_valid_o;
    addr_t req_addr_o;
    logic  req_ready_i;

    modport master (
        output cand_addr1_i, cand_vld1_i,
        output cand_addr2_i, cand_vld2_i,
        output cand_addr3_i, cand_vld3_i,
        output req_ready_i,
        input  req_valid_o, req_addr_o
    );

    modport slave (
        input  cand_addr1_i, cand_vld1_i,
        input  cand_addr2_i, cand_vld2_i,
        input  cand_addr3_i, cand_vld3_i,
        input  req_ready_i,
        output req_valid_o, req_addr_o
    );

endinterface

// File: rtl/pref_dedup_filter.sv
// Small CAM of recently issued line addresses: 3 lookup ports, 1 insert port, clear.
// Latency: lookups combinational against stored state; inserts visible the next cycle.
// Backpressure: none; round-robin replacement overwrites the oldest slot.
// Ports: clk, rst_n, clear (invalidate all), lookup_cla/hit (3 ports), ins_vld/ins_cla.
module pref_dedup_filter
    import pref_pkg::*;
#(
    parameter int FILTER_SIZE = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  cla_t [2:0]     lookup_cla,
    output logic [2:0]     hit,
    input  logic           ins_vld,
    input  cla_t           ins_cla
);

    localparam int IDX_W = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;

    cla_t                   tag [FILTER_SIZE];
    logic [FILTER_SIZE-1:0] vld;
    logic [IDX_W-1:0]       rr;

    always_comb begin
        hit = '0;
        for (int k = 0; k < 3; k++) begin
            for (int e = 0; e < FILTER_SIZE; e++) begin
                if (vld[e] && (tag[e] == lookup_cla[k])) begin
                    hit[k] = 1'b1;
                end
            end
        end
    end

    // Clear wins over a same-cycle insert: a flush empties the filter outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            rr  <= '0;
        end else if (clear) begin
            vld <= '0;
            rr  <= '0;
        end else if (ins_vld) begin
            vld[rr] <= 1'b1;
            rr      <= (rr == IDX_W'(FILTER_SIZE - 1)) ? '0 : rr + 1'b1;
        end
    end

    // Tags are qualified by vld, so they need no reset.
    always_ff @(posedge clk) begin
        if (ins_vld && !clear) begin
            tag[rr] <= ins_cla;
        end
    end

endmodule

// File: rtl/pref_issue_queue.sv
// Prefetch issue queue: up to 3 writes and 1 read per cycle, oldest first, with drop counter.
// Latency: a candidate written in cycle N is presented on req_* in cycle N+1.
// Backpressure: head held while req_valid_o & !req_ready_i; candidates beyond free space are dropped and counted.
// Ports: clk, rst_n, en_i, flush_i, bus (slave modport), occupancy_o, drop_cnt_o [, dup_cnt_o].
// Optional feature: macro PREF_DEDUP_EN enables duplicate suppression and dup_cnt_o.
module pref_issue_queue
    import pref_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int FILTER_SIZE = 4,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_i,
    input  logic                       flush_i,
    pref_issue_queue_if.slave          bus,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
    output logic [CNT_W-1:0]           drop_cnt_o
`ifdef PREF_DEDUP_EN
    ,
    output logic [CNT_W-1:0]           dup_cnt_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || FILTER_SIZE < 1) begin : g_bad_param
        $error("pref_issue_queue: DEPTH must be a power of 2 >= 4 and FILTER_SIZE >= 1");
    end

    addr_t            mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] occ;
    logic [CNT_W-1:0] drop_cnt;

    addr_t      cand_addr [3];
    logic [2:0] cand_vld;

    assign cand_addr[0] = blk_align(bus.cand_addr1_i);
    assign cand_addr[1] = blk_align(bus.cand_addr2_i);
    assign cand_addr[2] = blk_align(bus.cand_addr3_i);
    assign cand_vld     = {bus.cand_vld3_i, bus.cand_vld2_i, bus.cand_vld1_i};

    logic             pop;
    logic             accept;
    logic [OCC_W-1:0] free;

    assign pop    = (occ != '0) && bus.req_ready_i;
    assign accept = en_i && !flush_i;
    // Space is judged at the start of the cycle; a same-cycle pop does not help.
    assign free   = OCC_W'(DEPTH) - occ;

`ifdef PREF_DEDUP_EN
    logic [2:0]       fifo_hit;
    logic [2:0]       filt_hit;
    logic [2:0]       dup;
    cla_t [2:0]       lookup_cla;
    logic [PTR_W-1:0] offset;
    logic [CNT_W-1:0] dup_cnt;
    logic [1:0]       n_dup;

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        fifo_hit = '0;
        offset   = '0;
        for (int e = 0; e < DEPTH; e++) begin
            offset = PTR_W'(e) - rd_ptr;
            for (int k = 0; k < 3; k++) begin
                if ((OCC_W'(offset) < occ) && (mem[e] == cand_addr[k])) begin
                    fifo_hit[k] = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_lookup
        assign lookup_cla[k] = cand_addr[k][ADDR_SIZE-1:LOG2_BLOCK_SIZE];
    end

    pref_dedup_filter #(
        .FILTER_SIZE (FILTER_SIZE)
    ) u_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (flush_i),
        .lookup_cla (lookup_cla),
        .hit        (filt_hit),
        .ins_vld    (pop),
        .ins_cla    (mem[rd_ptr][ADDR_SIZE-1:LOG2_BLOCK_SIZE])
    );

    assign dup = fifo_hit | filt_hit;
`endif

    // Write packing: accepted candidates fill consecutive slots from wr_ptr in order 1,2,3.
    logic [1:0] n_wr;
    logic [1:0] n_drop;
    logic [2:0] wr_en;
    addr_t      wr_dat [3];
    logic       is_dup;

    always_comb begin
        n_wr   = '0;
        n_drop = '0;
        wr_en  = '0;
        is_dup = 1'b0;
        for (int j = 0; j < 3; j++) begin
            wr_dat[j] = '0;
        end
`ifdef PREF_DEDUP_EN
        n_dup = '0;
`endif
        for (int k = 0; k < 3; k++) begin
            if (accept && cand_vld[k]) begin
`ifdef PREF_DEDUP_EN
                is_dup = dup[k];
                for (int j = 0; j < 3; j++) begin
                    if ((2'(j) < n_wr) && (wr_dat[j] == cand_addr[k])) begin
                        is_dup = 1'b1;
                    end
                end
`else
                is_dup = 1'b0;
`endif
                if (is_dup) begin
`ifdef PREF_DEDUP_EN
                    n_dup = n_dup + 2'd1;
`endif
                end else if (OCC_W'(n_wr) < free) begin
                    wr_en[n_wr]  = 1'b1;
                    wr_dat[n_wr] = cand_addr[k];
                    n_wr         = n_wr + 2'd1;
                end else begin
                    n_drop = n_drop + 2'd1;
                end
            end
        end
    end

    logic [CNT_W:0] drop_sum;
    assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(n_drop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            drop_cnt <= '0;
        end else if (flush_i) begin
            // The head handshake of this cycle is still sent; everything left is discarded.
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            rd_ptr   <= rd_ptr + PTR_W'(pop);
            wr_ptr   <= wr_ptr + PTR_W'(n_wr);
            occ      <= occ + OCC_W'(n_wr) - OCC_W'(pop);
            drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    // Storage is qualified by occupancy, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int j = 0; j < 3; j++) begin
            if (wr_en[j]) begin
                mem[wr_ptr + PTR_W'(j)] <= wr_dat[j];
            end
        end
    end

`ifdef PREF_DEDUP_EN
    logic [CNT_W:0] dup_sum;
    assign dup_sum = {1'b0, dup_cnt} + (CNT_W+1)'(n_dup);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dup_cnt <= '0;
        end else begin
            dup_cnt <= dup_sum[CNT_W] ? '1 : dup_sum[CNT_W-1:0];
        end
    end

    assign dup_cnt_o = dup_cnt;
`endif

    // Outputs derive directly from reset state, so an async reset clears them at once.
    assign bus.req_valid_o = (occ != '0);
    assign bus.req_addr_o  = (occ != '0) ? mem[rd_ptr] : '0;
    assign occupancy_o     = occ;
    assign drop_cnt_o      = drop_cnt;

endmodule

// File: tb/tb_pref_issue_queue.sv
// Self-checking bench for pref_issue_queue against a queue-based reference model.
// Latency: model updates at each rising edge; outputs compared 1 time unit after it.
// Backpressure: req_ready_i driven by directed tests and randomly.
module tb_pref_issue_queue;
    import pref_pkg::*;

    localparam int DEPTH       = 8;
    localparam int FILTER_SIZE = 4;
    localparam int CNT_W       = 16;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             flush;
    logic [3:0]       occupancy;
    logic [CNT_W-1:0] drop_cnt;
`ifdef PREF_DEDUP_EN
    logic [CNT_W-1:0] dup_cnt;
`endif

    pref_issue_queue_if bus ();

    pref_issue_queue #(
        .DEPTH       (DEPTH),
        .FILTER_SIZE (FILTER_SIZE),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en),
        .flush_i     (flush),
        .bus         (bus.slave),
        .occupancy_o (occupancy),
        .drop_cnt_o  (drop_cnt)
`ifdef PREF_DEDUP_EN
        ,
        .dup_cnt_o   (dup_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the queue contents, oldest first, and the counters.
    addr_t mq[$];
    addr_t mfilt[$];
    int    m_drop = 0;
    int    m_dup  = 0;

    function automatic addr_t exp_addr();
        return (mq.size() != 0) ? mq[0] : 64'h0;
    endfunction

    task automatic set_cands(input addr_t a1, input bit v1, input addr_t a2, input bit v2,
                             input addr_t a3, input bit v3);
        bus.cand_addr1_i = a1; bus.cand_vld1_i = v1;
        bus.cand_addr2_i = a2; bus.cand_vld2_i = v2;
        bus.cand_addr3_i = a3; bus.cand_vld3_i = v3;
    endtask

    // Applies the queue rules to the inputs presented this cycle, then advances the clock.
    task automatic tick();
        addr_t ca [3];
        bit    cv [3];
        addr_t wr[$];
        int    free;
        bit    pop;
        bit    dupk;
        ca[0] = bus.cand_addr1_i & ~64'h3F; cv[0] = bus.cand_vld1_i;
        ca[1] = bus.cand_addr2_i & ~64'h3F; cv[1] = bus.cand_vld2_i;
        ca[2] = bus.cand_addr3_i & ~64'h3F; cv[2] = bus.cand_vld3_i;
        pop  = (mq.size() != 0) && bus.req_ready_i;
        free = DEPTH - mq.size();
        if (en && !flush) begin
            for (int k = 0; k < 3; k++) begin
                if (cv[k]) begin
                    dupk = 1'b0;
`ifdef PREF_DEDUP_EN
                    foreach (mq[i])    if (mq[i] == ca[k])    dupk = 1'b1;
                    foreach (mfilt[i]) if (mfilt[i] == ca[k]) dupk = 1'b1;
                    foreach (wr[i])    if (wr[i] == ca[k])    dupk = 1'b1;
`endif
                    if (dupk) begin
                        if (m_dup < CNT_MAX) m_dup++;
                    end else if (wr.size() < free) begin
                        wr.push_back(ca[k]);
                    end else begin
                        if (m_drop < CNT_MAX) m_drop++;
                    end
                end
            end
        end
        if (pop) begin
`ifdef PREF_DEDUP_EN
            mfilt.push_back(mq[0]);
            if (mfilt.size() > FILTER_SIZE) void'(mfilt.pop_front());
`endif
            void'(mq.pop_front());
        end
        if (flush) begin
            mq.delete();
            mfilt.delete();
        end else begin
            foreach (wr[i]) mq.push_back(wr[i]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        set_cands(64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        flush = 1'b0;
        en    = 1'b1;
    endtask

    task automatic drain_by_flush();
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.req_ready_i = 1'b0;
        #1;
        total++;
        if (bus.req_valid_o !== 1'b0 || bus.req_addr_o !== 64'h0 || occupancy !== 4'd0 ||
            drop_cnt !== '0) begin
            bad++;
            $display("FAIL reset: valid=%b addr=%h occ=%0d drop=%0d required 0/0/0/0",
                     bus.req_valid_o, bus.req_addr_o, occupancy, drop_cnt);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_issue();
        addr_t seq [3];
        seq[0] = 64'h1000; seq[1] = 64'h1040; seq[2] = 64'h1080;
        bus.req_ready_i = 1'b1;
        set_cands(64'h1000, 1'b1, 64'h1040, 1'b1, 64'h1080, 1'b1);
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.req_valid_o !== 1'b1 || bus.req_addr_o !== seq[i]) begin
                bad++;
                $display("FAIL basic_issue[%0d]: valid=%b addr=%h required 1/%h",
                         i, bus.req_valid_o, bus.req_addr_o, seq[i]);
            end
            tick();
        end
        total++;
        if (occupancy !== 4'd0 || bus.req_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL basic_drained: occ=%0d valid=%b required 0/0", occupancy, bus.req_valid_o);
        end
    endtask

    task automatic test_overflow();
        int exp_occ [4];
        int exp_drop [4];
        exp_occ[0] = 3; exp_occ[1] = 6; exp_occ[2] = 8; exp_occ[3] = 8;
        exp_drop[0] = 0; exp_drop[1] = 0; exp_drop[2] = 1; exp_drop[3] = 4;
        bus.req_ready_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_cands(64'h5000 + 64'(c * 192), 1'b1, 64'h5040 + 64'(c * 192), 1'b1,
                      64'h5080 + 64'(c * 192), 1'b1);
            tick();
            total++;
            if (int'(occupancy) != exp_occ[c] || int'(drop_cnt) != exp_drop[c] ||
                int'(drop_cnt) != m_drop) begin
                bad++;
                $display("FAIL overflow[%0d]: occ=%0d drop=%0d required %0d/%0d",
                         c, occupancy, drop_cnt, exp_occ[c], exp_drop[c]);
            end
        end
        // Full, three candidates, ready high: all dropped while the head still pops.
        bus.req_ready_i = 1'b1;
        set_cands(64'h6000, 1'b1, 64'h6040, 1'b1, 64'h6080, 1'b1);
        tick();
        total++;
        if (occupancy !== 4'd7 || int'(drop_cnt) != 7 || bus.req_addr_o !== 64'h5040) begin
            bad++;
            $display("FAIL full_pop: occ=%0d drop=%0d addr=%h required 7/7/5040",
                     occupancy, drop_cnt, bus.req_addr_o);
        end
        drain_by_flush();
    endtask

    task automatic test_backpressure();
        bus.req_ready_i = 1'b0;
        set_cands(64'h2000, 1'b1, 64'h2040, 1'b1, 64'h0, 1'b0);
        tick();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bus.req_valid_o !== 1'b1 || bus.req_addr_o !== 64'h2000) begin
                bad++;
                $display("FAIL backpressure_hold[%0d]: valid=%b addr=%h required 1/2000",
                         i, bus.req_valid_o, bus.req_addr_o);
            end
            tick();
        end
        bus.req_ready_i = 1'b1;
        tick();
        total++;
        if (bus.req_addr_o !== 64'h2040 || occupancy !== 4'd1) begin
            bad++;
            $display("FAIL backpressure_pop: addr=%h occ=%0d required 2040/1",
                     bus.req_addr_o, occupancy);
        end
        drain_by_flush();
    endtask

    task automatic test_align_enable();
        int drop_before;
        bus.req_ready_i = 1'b0;
        set_cands(64'h30FF, 1'b1, 64'h0, 1'b0, 64'h0, 1'b0);
        tick();
        total++;
        if (bus.req_addr_o !== 64'h30C0) begin
            bad++;
            $display("FAIL align: addr=%h required 30c0", bus.req_addr_o);
        end
        drop_before = int'(drop_cnt);
        en = 1'b0;
        set_cands(64'h7000, 1'b1, 64'h7040, 1'b1, 64'h7080, 1'b1);
        repeat (3) tick();
        total++;
        if (occupancy !== 4'd1 || int'(drop_cnt) != drop_before) begin
            bad++;
            $display("FAIL enable_off: occ=%0d drop=%0d required 1/%0d",
                     occupancy, drop_cnt, drop_before);
        end
        drain_by_flush();
    endtask

    task automatic test_flush();
        int drop_before;
        bus.req_ready_i = 1'b0;
        set_cands(64'h8000, 1'b1, 64'h8040, 1'b1, 64'h8080, 1'b1);
        tick();
        set_cands(64'h80C0, 1'b1, 64'h8100, 1'b1, 64'h0, 1'b0);
        tick();
        total++;
        if (occupancy !== 4'd5 || bus.req_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL flush_setup: occ=%0d valid=%b required 5/1", occupancy, bus.req_valid_o);
        end
        drop_before = int'(drop_cnt);
        bus.req_ready_i = 1'b1;
        flush = 1'b1;
        set_cands(64'h9000, 1'b1, 64'h9040, 1'b1, 64'h9080, 1'b1);
        tick();
        idle_inputs();
        total++;
        if (occupancy !== 4'd0 || bus.req_valid_o !== 1'b0 || int'(drop_cnt) != drop_before) begin
            bad++;
            $display("FAIL flush: occ=%0d valid=%b drop=%0d required 0/0/%0d",
                     occupancy, bus.req_valid_o, drop_cnt, drop_before);
        end
    endtask

    task automatic test_duplicates();
`ifdef PREF_DEDUP_EN
        int dup_before;
`endif
        drain_by_flush();
        bus.req_ready_i = 1'b1;
        set_cands(64'h4000, 1'b1, 64'h0, 1'b0, 64'h0, 1'b0);
        tick();
        idle_inputs();
        tick();
`ifdef PREF_DEDUP_EN
        dup_before = int'(dup_cnt);
`endif
        set_cands(64'h4000, 1'b1, 64'h4040, 1'b1, 64'h4040, 1'b1);
        tick();
        idle_inputs();
        bus.req_ready_i = 1'b0;
        total++;
`ifdef PREF_DEDUP_EN
        if (occupancy !== 4'd1 || bus.req_addr_o !== 64'h4040 || int'(dup_cnt) != dup_before + 2) begin
            bad++;
            $display("FAIL dedup: occ=%0d addr=%h dup=%0d required 1/4040/%0d",
                     occupancy, bus.req_addr_o, dup_cnt, dup_before + 2);
        end
`else
        if (occupancy !== 4'd3 || bus.req_addr_o !== 64'h4000) begin
            bad++;
            $display("FAIL no_dedup: occ=%0d addr=%h required 3/4000", occupancy, bus.req_addr_o);
        end
`endif
        drain_by_flush();
    endtask

    task automatic test_random();
        addr_t pool [6];
        for (int i = 0; i < 6; i++) pool[i] = 64'hA000 + 64'(i * 64);
        for (int c = 0; c < 400; c++) begin
            en              = ($urandom_range(0, 9) != 0);
            flush           = ($urandom_range(0, 39) == 0);
            bus.req_ready_i = ($urandom_range(0, 2) != 0);
            set_cands(pool[$urandom_range(0, 5)] | 64'($urandom_range(0, 63)), 1'($urandom),
                      pool[$urandom_range(0, 5)] | 64'($urandom_range(0, 63)), 1'($urandom),
                      pool[$urandom_range(0, 5)] | 64'($urandom_range(0, 63)), 1'($urandom));
            tick();
            total++;
            if (bus.req_valid_o !== (mq.size() != 0) || bus.req_addr_o !== exp_addr() ||
                int'(occupancy) != mq.size() || int'(drop_cnt) != m_drop
`ifdef PREF_DEDUP_EN
                || int'(dup_cnt) != m_dup
`endif
                ) begin
                bad++;
                $display("FAIL random[%0d]: valid=%b addr=%h occ=%0d drop=%0d required %b/%h/%0d/%0d",
                         c, bus.req_valid_o, bus.req_addr_o, occupancy, drop_cnt,
                         (mq.size() != 0), exp_addr(), mq.size(), m_drop);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midstream();
        bus.req_ready_i = 1'b0;
        set_cands(64'hB000, 1'b1, 64'hB040, 1'b1, 64'hB080, 1'b1);
        tick();
        idle_inputs();
        bus.req_ready_i = 1'b1;
        rst_n = 1'b0;
        #1;
        mq.delete();
        mfilt.delete();
        m_drop = 0;
        m_dup  = 0;
        total++;
        if (bus.req_valid_o !== 1'b0 || bus.req_addr_o !== 64'h0 || occupancy !== 4'd0 ||
            drop_cnt !== '0
`ifdef PREF_DEDUP_EN
            || dup_cnt !== '0
`endif
            ) begin
            bad++;
            $display("FAIL reset_midstream: valid=%b addr=%h occ=%0d drop=%0d required 0/0/0/0",
                     bus.req_valid_o, bus.req_addr_o, occupancy, drop_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_overflow();
        test_backpressure();
        test_align_enable();
        test_flush();
        test_duplicates();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
